// File: rtl/zet_ng_wb_mem_arbiter_if.sv
// Bus bundle for zet_ng_wb_mem_arbiter: packed per-master Wishbone request/response
// signals, the single downstream memory port and the one-hot grant.
interface zet_ng_wb_mem_arbiter_if #(
    parameter int NUM_MASTERS = 2,
    parameter int AW          = 27
);
    logic [NUM_MASTERS-1:0]      m_cyc_i;
    logic [NUM_MASTERS-1:0]      m_stb_i;
    logic [NUM_MASTERS-1:0]      m_we_i;
    logic [NUM_MASTERS*AW-1:0]   m_adr_i;
    logic [NUM_MASTERS*32-1:0]   m_dat_i;
    logic [NUM_MASTERS*4-1:0]    m_sel_i;
    logic [NUM_MASTERS*3-1:0]    m_cti_i;
    logic [NUM_MASTERS*2-1:0]    m_bte_i;
    logic [NUM_MASTERS-1:0]      m_ack_o;
    logic [NUM_MASTERS-1:0]      m_err_o;
    logic [NUM_MASTERS-1:0]      m_rty_o;
    logic [31:0]                 m_dat_o;

    logic                        s_cyc_o;
    logic                        s_stb_o;
    logic                        s_we_o;
    logic [AW-1:0]               s_adr_o;
    logic [31:0]                 s_dat_o;
    logic [3:0]                  s_sel_o;
    logic [2:0]                  s_cti_o;
    logic [1:0]                  s_bte_o;
    logic                        s_ack_i;
    logic                        s_err_i;
    logic                        s_rty_i;
    logic [31:0]                 s_dat_i;

    logic [NUM_MASTERS-1:0]      grant_o;

    // Handshake: a transfer completes in any cycle where stb (with cyc) is high and
    // exactly one of ack/err/rty is returned; cyc brackets the whole bus ownership.

    // Arbiter side: slave to the masters, master towards memory.
    modport slave (
        input  m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i, m_cti_i, m_bte_i,
        output m_ack_o, m_err_o, m_rty_o, m_dat_o,
        output s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o, s_cti_o, s_bte_o,
        input  s_ack_i, s_err_i, s_rty_i, s_dat_i,
        output grant_o
    );

    // Environment side: the requesting masters plus the memory that answers.
    modport master (
        output m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i, m_cti_i, m_bte_i,
        input  m_ack_o, m_err_o, m_rty_o, m_dat_o,
        input  s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o, s_cti_o, s_bte_o,
        output s_ack_i, s_err_i, s_rty_i, s_dat_i,
        input  grant_o
    );
endinterface

// File: rtl/zet_ng_wb_mem_arbiter.sv
// Round-robin Wishbone arbiter sharing one memory port between NUM_MASTERS masters,
// grant held for a whole cyc envelope. ZET_NG_WB_ARB_WATCHDOG_EN adds a stall watchdog.
module zet_ng_wb_mem_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int AW          = 27,
    parameter int TIMEOUT     = 1023
) (
    input  logic                          clk,
    input  logic                          rst,
    zet_ng_wb_mem_arbiter_if.slave        bus,
    output logic [1:0]                    state_o
);
    localparam int PW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] BUSY  = 2'd1;
`ifdef ZET_NG_WB_ARB_WATCHDOG_EN
    localparam logic [1:0] DRAIN = 2'd2;
`endif

    if (NUM_MASTERS < 2 || NUM_MASTERS > 4 || TIMEOUT < 1 || TIMEOUT > 1023) begin : g_param_check
        $error("zet_ng_wb_mem_arbiter: NUM_MASTERS must be 2..4 and TIMEOUT 1..1023");
    end

    logic [1:0]             state_q, state_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [PW-1:0]          gidx_q, gidx_d;
    logic [PW-1:0]          ptr_q, ptr_d;

    logic                   g_cyc, g_stb, g_we;
    logic [AW-1:0]          g_adr;
    logic [31:0]            g_dat;
    logic [3:0]             g_sel;
    logic [2:0]             g_cti;
    logic [1:0]             g_bte;

    logic                   busy, term, timeout;
    logic                   pick_found;
    logic [PW-1:0]          pick_idx, cand, next_idx;

`ifdef ZET_NG_WB_ARB_WATCHDOG_EN
    logic [9:0]             wd_cnt_q, wd_cnt_d;
`endif

    // Selected master's request signals.
    always_comb begin
        g_cyc = 1'b0;
        g_stb = 1'b0;
        g_we  = 1'b0;
        g_adr = '0;
        g_dat = '0;
        g_sel = '0;
        g_cti = '0;
        g_bte = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (gidx_q == PW'(i)) begin
                g_cyc = bus.m_cyc_i[i];
                g_stb = bus.m_stb_i[i];
                g_we  = bus.m_we_i[i];
                g_adr = bus.m_adr_i[i*AW +: AW];
                g_dat = bus.m_dat_i[i*32 +: 32];
                g_sel = bus.m_sel_i[i*4 +: 4];
                g_cti = bus.m_cti_i[i*3 +: 3];
                g_bte = bus.m_bte_i[i*2 +: 2];
            end
        end
    end

    // First requester at or after the round-robin pointer, wrapping.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            cand = PW'((int'(ptr_q) + k) % NUM_MASTERS);
            if (!pick_found && bus.m_cyc_i[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    assign next_idx = (gidx_q == PW'(NUM_MASTERS - 1)) ? '0 : gidx_q + 1'b1;
    assign busy     = (state_q == BUSY);
    assign term     = bus.s_ack_i | bus.s_err_i | bus.s_rty_i;

`ifdef ZET_NG_WB_ARB_WATCHDOG_EN
    // A termination in the timeout cycle wins, hence the ~term.
    assign timeout = busy & g_cyc & g_stb & ~term & (wd_cnt_q == 10'(TIMEOUT - 1));

    always_comb begin
        wd_cnt_d = wd_cnt_q;
        if (state_q == IDLE) begin
            wd_cnt_d = '0;
        end else if (busy) begin
            if (term) begin
                wd_cnt_d = '0;
            end else if (g_cyc && g_stb) begin
                wd_cnt_d = wd_cnt_q + 10'd1;
            end
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gidx_d  = gidx_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = BUSY;
                    gidx_d  = pick_idx;
                    grant_d = '0;
                    grant_d[pick_idx] = 1'b1;
                end
            end
            BUSY: begin
                if (!g_cyc) begin
                    state_d = IDLE;
                    grant_d = '0;
                    ptr_d   = next_idx;
                end else if (timeout) begin
`ifdef ZET_NG_WB_ARB_WATCHDOG_EN
                    state_d = DRAIN;
`endif
                end
            end
`ifdef ZET_NG_WB_ARB_WATCHDOG_EN
            DRAIN: begin
                if (!g_cyc) begin
                    state_d = IDLE;
                    grant_d = '0;
                    ptr_d   = next_idx;
                end
            end
`endif
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            ptr_q   <= ptr_d;
        end
    end

`ifdef ZET_NG_WB_ARB_WATCHDOG_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt_q <= '0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
        end
    end
`endif

    // Downstream port is quiet outside BUSY and in the timeout cycle.
    always_comb begin
        bus.s_cyc_o = busy & g_cyc & ~timeout;
        bus.s_stb_o = busy & g_cyc & g_stb & ~timeout;
        bus.s_we_o  = busy & g_we;
        bus.s_adr_o = busy ? g_adr : '0;
        bus.s_dat_o = busy ? g_dat : '0;
        bus.s_sel_o = busy ? g_sel : '0;
        bus.s_cti_o = busy ? g_cti : '0;
        bus.s_bte_o = busy ? g_bte : '0;
        bus.m_ack_o = busy ? (grant_q & {NUM_MASTERS{bus.s_ack_i}}) : '0;
        bus.m_err_o = busy ? (grant_q & {NUM_MASTERS{bus.s_err_i | timeout}}) : '0;
        bus.m_rty_o = busy ? (grant_q & {NUM_MASTERS{bus.s_rty_i}}) : '0;
        bus.m_dat_o = bus.s_dat_i;
        bus.grant_o = grant_q;
    end

    assign state_o = state_q;
endmodule

// File: tb/tb_zet_ng_wb_mem_arbiter.sv
// Directed self-checking bench for zet_ng_wb_mem_arbiter (2 masters, TIMEOUT=15).
module tb_zet_ng_wb_mem_arbiter;
    localparam int NM      = 2;
    localparam int AW      = 27;
    localparam int TIMEOUT = 15;

    logic       clk;
    logic       rst;
    logic [1:0] state_o;
    int         n_checks;
    int         n_fail;
    logic [31:0] exp_q[$];
    logic [31:0] exp_dat;

    zet_ng_wb_mem_arbiter_if #(.NUM_MASTERS(NM), .AW(AW)) bus();

    zet_ng_wb_mem_arbiter #(.NUM_MASTERS(NM), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .state_o (state_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drive_master(input int i, input logic cyc, input logic stb, input logic we,
                                input logic [AW-1:0] adr, input logic [31:0] dat,
                                input logic [2:0] cti);
        bus.m_cyc_i[i]           = cyc;
        bus.m_stb_i[i]           = stb;
        bus.m_we_i[i]            = we;
        bus.m_adr_i[i*AW +: AW]  = adr;
        bus.m_dat_i[i*32 +: 32]  = dat;
        bus.m_sel_i[i*4 +: 4]    = 4'hF;
        bus.m_cti_i[i*3 +: 3]    = cti;
        bus.m_bte_i[i*2 +: 2]    = 2'b00;
    endtask

    task automatic release_master(input int i);
        drive_master(i, 1'b0, 1'b0, 1'b0, '0, '0, 3'b000);
    endtask

    task automatic slave_resp(input logic ack, input logic err, input logic rty,
                              input logic [31:0] dat);
        bus.s_ack_i = ack;
        bus.s_err_i = err;
        bus.s_rty_i = rty;
        bus.s_dat_i = dat;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        release_master(0);
        release_master(1);
        slave_resp(1'b0, 1'b0, 1'b0, '0);
        repeat (3) step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        settle();
        n_checks++;
        if (state_o !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", state_o); end
        n_checks++;
        if (bus.grant_o !== 2'b00) begin n_fail++; $display("FAIL reset_grant: got %b want 00", bus.grant_o); end
        n_checks++;
        if ({bus.s_cyc_o, bus.s_stb_o, bus.s_we_o} !== 3'b000) begin
            n_fail++; $display("FAIL reset_s_strobes: got %b want 000", {bus.s_cyc_o, bus.s_stb_o, bus.s_we_o});
        end
        n_checks++;
        if ({bus.m_ack_o, bus.m_err_o, bus.m_rty_o} !== 6'b0) begin
            n_fail++; $display("FAIL reset_m_terms: got %b want 000000", {bus.m_ack_o, bus.m_err_o, bus.m_rty_o});
        end
    endtask

    task automatic test_single_read();
        step();
        drive_master(0, 1'b1, 1'b1, 1'b0, 27'h100, '0, 3'b000);
        settle();
        n_checks++;
        if (bus.s_cyc_o !== 1'b0) begin n_fail++; $display("FAIL single_latency: s_cyc got %b want 0", bus.s_cyc_o); end
        step(); settle();
        n_checks++;
        if (bus.s_cyc_o !== 1'b1 || bus.grant_o !== 2'b01) begin
            n_fail++; $display("FAIL single_grant: s_cyc %b grant %b want 1 01", bus.s_cyc_o, bus.grant_o);
        end
        n_checks++;
        if (bus.s_adr_o !== 27'h100) begin n_fail++; $display("FAIL single_adr: got %h want 100", bus.s_adr_o); end
        step(); settle();
        n_checks++;
        if (bus.m_ack_o !== 2'b00) begin n_fail++; $display("FAIL single_wait: ack got %b want 00", bus.m_ack_o); end
        step();
        slave_resp(1'b1, 1'b0, 1'b0, 32'hDEADBEEF);
        settle();
        n_checks++;
        if (bus.m_ack_o !== 2'b01) begin n_fail++; $display("FAIL single_ack: got %b want 01", bus.m_ack_o); end
        n_checks++;
        if (bus.m_dat_o !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_rdata: got %h want deadbeef", bus.m_dat_o); end
        step();
        slave_resp(1'b0, 1'b0, 1'b0, '0);
        release_master(0);
        settle();
        n_checks++;
        if (bus.s_cyc_o !== 1'b0 || bus.grant_o !== 2'b01 || bus.m_ack_o !== 2'b00) begin
            n_fail++; $display("FAIL single_drop: s_cyc %b grant %b ack %b want 0 01 00", bus.s_cyc_o, bus.grant_o, bus.m_ack_o);
        end
        step(); settle();
        n_checks++;
        if (bus.grant_o !== 2'b00) begin n_fail++; $display("FAIL single_release: grant got %b want 00", bus.grant_o); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        step();
        drive_master(0, 1'b1, 1'b1, 1'b0, 27'h10, '0, 3'b000);
        drive_master(1, 1'b1, 1'b1, 1'b0, 27'h20, '0, 3'b000);
        step(); settle();
        n_checks++;
        if (bus.grant_o !== 2'b01 || bus.s_adr_o !== 27'h10) begin
            n_fail++; $display("FAIL sim_first: grant %b adr %h want 01 010", bus.grant_o, bus.s_adr_o);
        end
        step();
        slave_resp(1'b1, 1'b0, 1'b0, 32'h1111_0000);
        settle();
        n_checks++;
        if (bus.m_ack_o !== 2'b01) begin n_fail++; $display("FAIL sim_ack0: got %b want 01", bus.m_ack_o); end
        step();
        slave_resp(1'b0, 1'b0, 1'b0, '0);
        release_master(0);
        step();
        drive_master(0, 1'b1, 1'b1, 1'b0, 27'h30, '0, 3'b000);
        settle();
        n_checks++;
        if (bus.grant_o !== 2'b00 || bus.s_cyc_o !== 1'b0) begin
            n_fail++; $display("FAIL sim_gap: grant %b s_cyc %b want 00 0", bus.grant_o, bus.s_cyc_o);
        end
        step(); settle();
        n_checks++;
        if (bus.grant_o !== 2'b10 || bus.s_adr_o !== 27'h20) begin
            n_fail++; $display("FAIL sim_second: grant %b adr %h want 10 020", bus.grant_o, bus.s_adr_o);
        end
        step();
        slave_resp(1'b1, 1'b0, 1'b0, 32'h2222_0000);
        settle();
        n_checks++;
        if (bus.m_ack_o !== 2'b10) begin n_fail++; $display("FAIL sim_ack1: got %b want 10", bus.m_ack_o); end
        step();
        slave_resp(1'b0, 1'b0, 1'b0, '0);
        release_master(1);
        step(); settle();
        n_checks++;
        if (bus.grant_o !== 2'b00) begin n_fail++; $display("FAIL sim_gap2: grant %b want 00", bus.grant_o); end
        step(); settle();
        n_checks++;
        if (bus.grant_o !== 2'b01 || bus.s_adr_o !== 27'h30) begin
            n_fail++; $display("FAIL sim_third: grant %b adr %h want 01 030", bus.grant_o, bus.s_adr_o);
        end
        step();
        release_master(0);
        step(); settle();
        n_checks++;
        if (bus.grant_o !== 2'b00) begin n_fail++; $display("FAIL sim_end: grant %b want 00", bus.grant_o); end
    endtask

    task automatic test_burst();
        step();
        drive_master(1, 1'b1, 1'b1, 1'b1, 27'h200, 32'hB000_0000, 3'b010);
        step();
        drive_master(0, 1'b1, 1'b1, 1'b0, 27'h500, '0, 3'b000);
        settle();
        n_checks++;
        if (bus.grant_o !== 2'b10 || bus.s_cti_o !== 3'b010 || bus.s_we_o !== 1'b1) begin
            n_fail++; $display("FAIL burst_grant: grant %b cti %b we %b want 10 010 1", bus.grant_o, bus.s_cti_o, bus.s_we_o);
        end
        for (int b = 0; b < 4; b++) begin
            step();
            drive_master(1, 1'b1, 1'b1, 1'b1, 27'(27'h200 + 4 * b), 32'hB000_0000 + b,
                         (b == 3) ? 3'b111 : 3'b010);
            slave_resp(1'b1, 1'b0, 1'b0, 32'hA000_0000 + b);
            exp_q.push_back(32'hA000_0000 + b);
            settle();
            exp_dat = exp_q.pop_front();
            n_checks++;
            if (bus.m_ack_o !== 2'b10 || bus.m_dat_o !== exp_dat) begin
                n_fail++; $display("FAIL burst_beat%0d: ack %b dat %h want 10 %h", b, bus.m_ack_o, bus.m_dat_o, exp_dat);
            end
            n_checks++;
            if (bus.s_adr_o !== 27'(27'h200 + 4 * b) || bus.s_cti_o !== ((b == 3) ? 3'b111 : 3'b010)
                || bus.s_dat_o !== 32'hB000_0000 + b) begin
                n_fail++; $display("FAIL burst_fwd%0d: adr %h cti %b dat %h", b, bus.s_adr_o, bus.s_cti_o, bus.s_dat_o);
            end
        end
        step();
        slave_resp(1'b0, 1'b0, 1'b0, '0);
        release_master(1);
        settle();
        n_checks++;
        if (bus.grant_o !== 2'b10 || bus.m_ack_o !== 2'b00) begin
            n_fail++; $display("FAIL burst_hold: grant %b ack %b want 10 00", bus.grant_o, bus.m_ack_o);
        end
        step(); settle();
        n_checks++;
        if (bus.grant_o !== 2'b00) begin n_fail++; $display("FAIL burst_gap: grant %b want 00", bus.grant_o); end
        step(); settle();
        n_checks++;
        if (bus.grant_o !== 2'b01 || bus.s_adr_o !== 27'h500) begin
            n_fail++; $display("FAIL burst_switch: grant %b adr %h want 01 500", bus.grant_o, bus.s_adr_o);
        end
        step();
        slave_resp(1'b1, 1'b0, 1'b0, '0);
        settle();
        n_checks++;
        if (bus.m_ack_o !== 2'b01) begin n_fail++; $display("FAIL burst_m0_ack: got %b want 01", bus.m_ack_o); end
        step();
        slave_resp(1'b0, 1'b0, 1'b0, '0);
        release_master(0);
        step();
    endtask

    task automatic test_err_rty();
        step();
        drive_master(0, 1'b1, 1'b1, 1'b1, 27'h300, 32'hCAFE_F00D, 3'b000);
        step(); settle();
        n_checks++;
        if (bus.grant_o !== 2'b01 || bus.s_we_o !== 1'b1 || bus.s_dat_o !== 32'hCAFE_F00D) begin
            n_fail++; $display("FAIL err_grant: grant %b we %b dat %h", bus.grant_o, bus.s_we_o, bus.s_dat_o);
        end
        step();
        slave_resp(1'b0, 1'b1, 1'b0, '0);
        settle();
        n_checks++;
        if ({bus.m_ack_o, bus.m_err_o, bus.m_rty_o} !== 6'b00_01_00) begin
            n_fail++; $display("FAIL err_route: ack/err/rty got %b want 000100", {bus.m_ack_o, bus.m_err_o, bus.m_rty_o});
        end
        step();
        slave_resp(1'b0, 1'b0, 1'b0, '0);
        release_master(0);
        step();
        drive_master(0, 1'b1, 1'b1, 1'b0, 27'h304, '0, 3'b000);
        step(); settle();
        n_checks++;
        if (bus.grant_o !== 2'b01) begin n_fail++; $display("FAIL rty_grant: grant %b want 01", bus.grant_o); end
        step();
        slave_resp(1'b0, 1'b0, 1'b1, '0);
        settle();
        n_checks++;
        if ({bus.m_ack_o, bus.m_err_o, bus.m_rty_o} !== 6'b00_00_01) begin
            n_fail++; $display("FAIL rty_route: ack/err/rty got %b want 000001", {bus.m_ack_o, bus.m_err_o, bus.m_rty_o});
        end
        step();
        slave_resp(1'b0, 1'b0, 1'b0, '0);
        release_master(0);
        step(); settle();
        n_checks++;
        if (bus.grant_o !== 2'b00) begin n_fail++; $display("FAIL rty_release: grant %b want 00", bus.grant_o); end
    endtask

    task automatic test_reset_mid_burst();
        step();
        drive_master(1, 1'b1, 1'b1, 1'b0, 27'h400, '0, 3'b010);
        step(); settle();
        n_checks++;
        if (bus.grant_o !== 2'b10) begin n_fail++; $display("FAIL rmb_grant: grant %b want 10", bus.grant_o); end
        step();
        slave_resp(1'b1, 1'b0, 1'b0, 32'h0000_0001);
        settle();
        n_checks++;
        if (bus.m_ack_o !== 2'b10) begin n_fail++; $display("FAIL rmb_beat1: ack %b want 10", bus.m_ack_o); end
        step();
        drive_master(1, 1'b1, 1'b1, 1'b0, 27'h404, '0, 3'b010);
        slave_resp(1'b1, 1'b0, 1'b0, 32'h0000_0002);
        rst = 1'b1;
        step();
        rst = 1'b0;
        slave_resp(1'b0, 1'b0, 1'b0, '0);
        settle();
        n_checks++;
        if (bus.s_cyc_o !== 1'b0 || bus.grant_o !== 2'b00 || state_o !== 2'd0) begin
            n_fail++; $display("FAIL rmb_reset: s_cyc %b grant %b state %0d want 0 00 0", bus.s_cyc_o, bus.grant_o, state_o);
        end
        step(); settle();
        n_checks++;
        if (bus.grant_o !== 2'b10 || bus.s_cyc_o !== 1'b1) begin
            n_fail++; $display("FAIL rmb_regrant: grant %b s_cyc %b want 10 1", bus.grant_o, bus.s_cyc_o);
        end
        step();
        release_master(1);
        step(); settle();
        n_checks++;
        if (bus.grant_o !== 2'b00) begin n_fail++; $display("FAIL rmb_release: grant %b want 00", bus.grant_o); end
    endtask

`ifdef ZET_NG_WB_ARB_WATCHDOG_EN
    task automatic test_watchdog();
        step();
        drive_master(0, 1'b1, 1'b1, 1'b0, 27'h600, '0, 3'b000);
        drive_master(1, 1'b1, 1'b1, 1'b0, 27'h700, '0, 3'b000);
        for (int k = 1; k < TIMEOUT; k++) begin
            step(); settle();
            n_checks++;
            if (bus.m_err_o !== 2'b00 || bus.s_stb_o !== 1'b1) begin
                n_fail++; $display("FAIL wd_stall%0d: err %b stb %b want 00 1", k, bus.m_err_o, bus.s_stb_o);
            end
        end
        step(); settle();
        n_checks++;
        if (bus.m_err_o !== 2'b01 || bus.s_cyc_o !== 1'b0 || bus.s_stb_o !== 1'b0) begin
            n_fail++; $display("FAIL wd_fire: err %b cyc %b stb %b want 01 0 0", bus.m_err_o, bus.s_cyc_o, bus.s_stb_o);
        end
        step(); settle();
        n_checks++;
        if (bus.m_err_o !== 2'b00 || bus.s_cyc_o !== 1'b0 || bus.grant_o !== 2'b01 || state_o !== 2'd2) begin
            n_fail++; $display("FAIL wd_drain: err %b cyc %b grant %b state %0d", bus.m_err_o, bus.s_cyc_o, bus.grant_o, state_o);
        end
        step();
        release_master(0);
        step(); settle();
        n_checks++;
        if (bus.grant_o !== 2'b00) begin n_fail++; $display("FAIL wd_release: grant %b want 00", bus.grant_o); end
        step(); settle();
        n_checks++;
        if (bus.grant_o !== 2'b10 || bus.s_adr_o !== 27'h700) begin
            n_fail++; $display("FAIL wd_next: grant %b adr %h want 10 700", bus.grant_o, bus.s_adr_o);
        end
        step();
        slave_resp(1'b1, 1'b0, 1'b0, '0);
        settle();
        n_checks++;
        if (bus.m_ack_o !== 2'b10 || bus.m_err_o !== 2'b00) begin
            n_fail++; $display("FAIL wd_served: ack %b err %b want 10 00", bus.m_ack_o, bus.m_err_o);
        end
        step();
        slave_resp(1'b0, 1'b0, 1'b0, '0);
        release_master(1);
        step();
    endtask
`else
    task automatic test_no_watchdog();
        step();
        drive_master(0, 1'b1, 1'b1, 1'b0, 27'h600, '0, 3'b000);
        for (int k = 1; k <= 20; k++) begin
            step(); settle();
            n_checks++;
            if (bus.m_err_o !== 2'b00 || bus.s_cyc_o !== 1'b1) begin
                n_fail++; $display("FAIL nowd_stall%0d: err %b cyc %b want 00 1", k, bus.m_err_o, bus.s_cyc_o);
            end
        end
        step();
        slave_resp(1'b1, 1'b0, 1'b0, '0);
        settle();
        n_checks++;
        if (bus.m_ack_o !== 2'b01) begin n_fail++; $display("FAIL nowd_ack: ack %b want 01", bus.m_ack_o); end
        step();
        slave_resp(1'b0, 1'b0, 1'b0, '0);
        release_master(0);
        step();
    endtask
`endif

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        bus.m_cyc_i = '0;
        bus.m_stb_i = '0;
        bus.m_we_i  = '0;
        bus.m_adr_i = '0;
        bus.m_dat_i = '0;
        bus.m_sel_i = '0;
        bus.m_cti_i = '0;
        bus.m_bte_i = '0;
        slave_resp(1'b0, 1'b0, 1'b0, '0);

        test_reset();
        test_single_read();
        test_simultaneous();
        test_burst();
        test_err_rty();
        test_reset_mid_burst();
`ifdef ZET_NG_WB_ARB_WATCHDOG_EN
        test_watchdog();
`else
        test_no_watchdog();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/zet_ng_wb_mem_arbiter.md
Name: zet_ng_wb_mem_arbiter

Overview:
- Shares the single external Wishbone memory port between NUM_MASTERS Wishbone masters.
- Master 0 is the Zet CPU bus; master 1 is the debug MAM (memory access module).
- Round-robin arbitration at Wishbone cycle granularity; a grant is held for the whole cyc_o envelope, including incrementing bursts.
- Sits between the masters and the wb_ext_* memory interface of the SoC core.

Parameters:
- NUM_MASTERS, 2, number of requesting masters (2..4).
- AW, 27, address width; equals $clog2(MEM_SIZE) for 128 MiB.
- TIMEOUT, 1023, stall limit in cycles; used only with the watchdog feature.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- m_cyc_i  in  NUM_MASTERS  per-master cyc.
- m_stb_i  in  NUM_MASTERS  per-master stb.
- m_we_i  in  NUM_MASTERS  per-master we.
- m_adr_i  in  NUM_MASTERS*AW  packed addresses; master i occupies [i*AW +: AW].
- m_dat_i  in  NUM_MASTERS*32  packed write data.
- m_sel_i  in  NUM_MASTERS*4  packed byte selects.
- m_cti_i  in  NUM_MASTERS*3  packed cycle type.
- m_bte_i  in  NUM_MASTERS*2  packed burst type.
- m_ack_o  out  NUM_MASTERS  per-master ack.
- m_err_o  out  NUM_MASTERS  per-master err.
- m_rty_o  out  NUM_MASTERS  per-master rty.
- m_dat_o  out  32  read data, broadcast to all masters.
- s_cyc_o, s_stb_o, s_we_o  out  1 each  slave strobes.
- s_adr_o  out  AW  slave address.
- s_dat_o  out  32  slave write data.
- s_sel_o  out  4  slave byte selects.
- s_cti_o  out  3  slave cycle type.
- s_bte_o  out  2  slave burst type.
- s_ack_i, s_err_i, s_rty_i  in  1 each  slave terminations.
- s_dat_i  in  32  slave read data.
- grant_o  out  NUM_MASTERS  one-hot current owner; all zero when idle.

Behaviour:
- States: IDLE, BUSY, DRAIN. DRAIN exists only with the watchdog feature.
- Reset values:
  - state=IDLE, grant_o=0, round-robin pointer=master 0.
  - All s_* outputs are 0; m_ack_o, m_err_o, m_rty_o are 0.
  - Reset asserted mid-cycle forces these values on the next clk edge; the slave sees cyc drop with no further handshake.
- IDLE:
  - If any m_cyc_i is set, pick the first requester at or after the pointer, wrapping modulo NUM_MASTERS.
  - Register the one-hot grant and go to BUSY. Arbitration latency is 1 clk (cyc seen in cycle N, s_cyc_o high in N+1).
  - With no request, stay in IDLE.
- BUSY:
  - s_cyc_o = m_cyc_i[g]; s_stb_o = m_stb_i[g] & m_cyc_i[g].
  - s_we/adr/dat/sel/cti/bte are combinational muxes of master g.
  - m_ack_o[g]=s_ack_i, m_err_o[g]=s_err_i, m_rty_o[g]=s_rty_i. Non-granted masters see 0.
  - m_dat_o = s_dat_i unconditionally.
- Release:
  - When m_cyc_i[g]=0 is sampled in BUSY, go to IDLE, clear grant_o, and set pointer=(g+1) mod NUM_MASTERS.
  - Exactly one idle gap cycle (s_cyc_o=0) always precedes the next grant.
- Bursts: cti/bte pass through unchanged. The grant never switches mid-burst or between back-to-back accesses while cyc stays high.
- Starvation: a master may hold cyc indefinitely without the watchdog. Fairness is guaranteed per cycle only.
- Simultaneous requests in IDLE: the pointer decides. After reset, master 0 wins.
- Combinational s_* outputs are 0 whenever state != BUSY.

Optional Feature:
- Macro: ZET_NG_WB_ARB_WATCHDOG_EN.
- Defined:
  - A 10-bit counter clears on entering BUSY and on any s_ack/err/rty.
  - It increments each cycle s_stb_o=1 without a termination.
  - When it reaches TIMEOUT, m_err_o[g] is pulsed for 1 clk, s_cyc_o/s_stb_o are forced 0 that cycle, and the state goes to DRAIN.
  - DRAIN holds grant_o and keeps s_* at 0 until m_cyc_i[g]=0, then goes to IDLE with the pointer advanced.
  - A termination arriving in the same cycle as the timeout wins: it is forwarded and the counter clears.
- Undefined: no counter and no DRAIN state; the arbiter never terminates a cycle itself.

Test Plan:
- Single master: master 0 single read at adr 0x100 with s_ack after 2 wait states -> s_cyc_o rises 1 clk after m_cyc_i; m_ack_o=2'b01 once; m_dat_o=s_dat_i=0xDEADBEEF; grant_o returns to 0 one clk after cyc drops.
- Simultaneous: both masters raise cyc the same cycle after reset -> master 0 granted first; after it releases, 1 gap cycle, then master 1 granted; a repeat then grants master 1 first (pointer=1).
- Burst: master 1 4-beat incrementing burst (cti=3'b010, last 3'b111, bte=0) while master 0 requests -> all 4 acks go to master 1; master 0 m_ack_o stays 0; grant switches only after master 1's cyc drops.
- Error and retry: slave returns s_err_i for master 0 write, then s_rty_i on the next access -> routed only to master 0; master 1 outputs remain 0.
- Reset mid-burst: rst asserted on beat 2 -> next edge s_cyc_o=0, grant_o=0; after release, master 1 alone requesting is granted in 1 clk.
- Watchdog (macro defined, TIMEOUT=15): slave never acks -> m_err_o[g] pulses exactly at the 15th stalled stb cycle; s_cyc_o low until the master drops cyc; the other master is then served normally.
